weight_fetch_sequencer: RTL and testbench
=========================================

# weight_fetch_sequencer

Read-side master for the weight ROM. On a start command, it walks a contiguous span of ROM addresses, driving `rom_address`/`rom_enable` and capturing `rom_data`. It forwards the weights, in order, as a valid/ready stream to the neuron MAC datapath. Backpressure from the MAC stalls ROM reads through a small credit-checked FIFO, so no weight is lost or duplicated.

## Interface
- `ADDR_W`, 8: ROM address width.
- `DATA_W`, 8: weight width.
- `DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first ROM address, latched on accepted `start`.
- `count`  in  ADDR_W+1  number of weights, 0..2^ADDR_W, latched on accepted `start`.
- `busy`  out  1  high in FETCH/DRAIN.
- `done`  out  1  one-cycle pulse when the command completes.
- `rom_address`  out  ADDR_W  registered ROM address.
- `rom_enable`  out  1  registered ROM read enable.
- `rom_data`  in  DATA_W  ROM output, valid during the cycle `rom_enable` is high.
- `w_data`  out  DATA_W  weight stream data (FIFO head).
- `w_valid`  out  1  stream valid.
- `w_ready`  in  1  stream ready from the MAC.
- `w_last`  out  1  marks the final weight of the command; qualified by `w_valid`.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - `start`=1 and `count`≠0: latch `base_addr` into the next-address register and `count` into the remaining-issue and remaining-deliver counters, then go to FETCH.
  - `start`=1 and `count`=0: pulse `done` on the next cycle and stay in IDLE. No ROM access occurs.
- FETCH: a read is issued at a clock edge when issues remain and `occupancy + inflight < DEPTH`. A read is issued as follows:
  - `rom_enable`←1 and `rom_address`←next address.
  - Next address increments modulo 2^ADDR_W (0xFF wraps to 0x00).
  - The issue counter decrements.
  - Otherwise `rom_enable`←0 and `rom_address` holds its value.
  - After the last issue, go to DRAIN.
- Capture: in every cycle with `rom_enable`=1, `rom_data` is written into the FIFO at the next edge. `inflight` is therefore 0 or 1.
- FIFO delivery:
  - The FIFO is first-word-fall-through; `w_valid` = FIFO not empty.
  - A word is consumed when `w_valid`&&`w_ready`.
  - A simultaneous write and read on the same edge leaves occupancy unchanged.
  - `w_last`=1 when the head word is the final one, i.e. the remaining-deliver counter equals 1.
- DRAIN: when the final word is consumed, return to IDLE and pulse `done` for one cycle on the following cycle.
- `start` in FETCH/DRAIN is ignored. A `start` coincident with the `done` cycle is accepted only if the state is already IDLE.
- `reset` (any state, including mid-transfer), applied at the next edge:
  - state→IDLE; FIFO flushed; counters cleared.
  - `rom_enable`=0, `rom_address`=0, `w_valid`=0, `w_last`=0, `busy`=0, `done`=0.
  - No `done` is generated for the aborted command.

## Timing
- Reset values: all outputs 0.
- Accept edge E0 (`start` sampled in IDLE):
  - `busy`=1 and `rom_enable`=1 with `rom_address`=base after E0.
  - The first word is written at E1, so `w_valid`=1 after E1. Start-to-data latency is 2 cycles.
- With `w_ready` held high: one ROM read and one output word per cycle; a command of N words issues in N consecutive cycles.
- `done` is asserted in the cycle after the edge that consumes the final word. `busy` falls on that same edge.
- Under backpressure:
  - `rom_enable` deasserts once `occupancy + inflight` reaches DEPTH.
  - Issuing resumes the cycle after space frees.
  - `w_data`/`w_valid`/`w_last` are stable while `w_valid`&&!`w_ready`.
- `count`=2^ADDR_W (256) reads every address exactly once, starting at `base_addr` and wrapping.

## Test plan
- Reset: hold `reset` 2 cycles → all outputs 0. Then `start` with `count`=3 in the same cycle as `reset` → ignored, no `rom_enable`.
- Basic: `base_addr`=0x10, `count`=4, `w_ready`=1 →
  - `rom_address` 0x10,0x11,0x12,0x13 on 4 consecutive cycles.
  - `w_data` equals the ROM contents in order, first `w_valid` 2 cycles after start.
  - `w_last` only on the 4th word; `done` one cycle after the 4th handshake.
- Backpressure: `count`=10, `w_ready` low for 6 cycles after the 2nd word →
  - Occupancy never exceeds 4 and `rom_enable` stalls.
  - All 10 words are delivered once, in order, with held data stable while stalled.
- Wrap: `base_addr`=0xFE, `count`=4 → addresses 0xFE,0xFF,0x00,0x01; `done` pulses once.
- Zero length: `count`=0 → no `rom_enable`, `busy` stays 0, `done` pulses the cycle after start.
- Abort/ignore:
  - A second `start` during FETCH is ignored: addresses are unchanged and no extra words are produced.
  - `reset` after the 3rd word of a 8-word command clears the FIFO and `w_valid` next cycle; no `done` pulse.
  - A subsequent fresh command runs correctly.

Source files
------------

// File: rtl/weight_fetch_sequencer.sv
// Walks a contiguous ROM span on start and streams the weights out through a FIFO; start-to-data latency is 2 cycles.
// ROM reads issue only while FIFO occupancy plus the in-flight read is below DEPTH, so w_ready backpressure stalls reads without loss.

module wfs_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     used
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (used == '0);
endmodule

module weight_fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_enable,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   deliver_left;
  logic [CW-1:0]     occupancy;
  logic              fifo_empty;
  logic              pop;
  logic              can_issue;
  logic              accept;
  logic              issue;
  logic              finish;
  logic              zero_cmd;

  assign pop       = !fifo_empty && w_ready;
  // The in-flight read already owns a FIFO slot, so it counts against the credit.
  assign can_issue = (issue_left != '0) && ((occupancy + CW'(rom_enable)) < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    zero_cmd  = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            accept    = 1'b1;
            state_nxt = (count == CNT_ONE) ? DRAIN : FETCH;
          end else begin
            zero_cmd = 1'b1;
          end
        end
      end
      FETCH: begin
        if (can_issue) begin
          issue = 1'b1;
          if (issue_left == CNT_ONE) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (deliver_left == CNT_ONE)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The accepting edge issues the first read itself, giving the 2-cycle start-to-data latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr    <= '0;
      issue_left   <= '0;
      deliver_left <= '0;
      rom_address  <= '0;
      rom_enable   <= 1'b0;
      done         <= 1'b0;
    end else begin
      done       <= zero_cmd || finish;
      rom_enable <= accept || issue;
      if (accept) begin
        rom_address <= base_addr;
        next_addr   <= base_addr + ADDR_W'(1);
        issue_left  <= count - CNT_ONE;
      end else if (issue) begin
        rom_address <= next_addr;
        next_addr   <= next_addr + ADDR_W'(1);
        issue_left  <= issue_left - CNT_ONE;
      end
      if (accept)   deliver_left <= count;
      else if (pop) deliver_left <= deliver_left - CNT_ONE;
    end
  end

  wfs_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rom_enable),
    .push_data (rom_data),
    .pop       (pop),
    .head      (w_data),
    .empty     (fifo_empty),
    .used      (occupancy)
  );

  assign w_valid = !fifo_empty;
  assign w_last  = w_valid && (deliver_left == CNT_ONE);
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed and randomized commands against a ROM with random contents; expected streams derived from base+i arithmetic.
module tb_weight_fetch_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] count = '0;
  logic       busy, done, rom_enable, w_valid, w_last;
  logic [7:0] rom_address, rom_data, w_data;
  logic       w_ready = 1'b0;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_address];

  weight_fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .rom_address(rom_address), .rom_enable(rom_enable),
    .rom_data(rom_data), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [7:0] iss_q [$];
  logic [8:0] got_q [$];
  int cyc = 0;
  int iss_first, iss_last, first_valid_cyc, done_cnt, done_cyc, last_hs_cyc;
  int max_out, stall_err;
  bit busy_seen, prev_stall, prev_last;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    iss_q.delete();
    got_q.delete();
    iss_first = -1; iss_last = -1; first_valid_cyc = -1;
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    max_out = 0; stall_err = 0; busy_seen = 0; prev_stall = 0;
  endtask

  // Samples outputs at the falling edge, then advances past the next rising edge.
  task automatic tick();
    int outstanding;
    @(negedge clk);
    cyc++;
    if (rom_enable) begin
      if (iss_q.size() == 0) iss_first = cyc;
      iss_last = cyc;
      iss_q.push_back(rom_address);
    end
    outstanding = iss_q.size() - got_q.size();
    if (outstanding > max_out) max_out = outstanding;
    if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall && !(w_valid === 1'b1 && w_data === prev_data && w_last === prev_last)) stall_err++;
    prev_stall = w_valid && !w_ready;
    prev_data  = w_data;
    prev_last  = w_last;
    if (w_valid && w_ready) begin
      got_q.push_back({w_last, w_data});
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1;
    @(posedge clk);
    #2;
  endtask

  function automatic logic pick_ready(input int mode, inout int stall_left);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom % 4) != 0;
    if (got_q.size() >= 2 && stall_left > 0) begin
      stall_left--;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // mode 0: ready held high, 1: random ready, 2: six stalled cycles after the 2nd word.
  task automatic run_cmd(input string name, input logic [7:0] base, input int cnt, input int mode, input int ign_at);
    int k;
    int start_cyc;
    int stall_left;
    int bad;
    logic [7:0] a;
    logic [8:0] exp_w;
    stall_left = 6;
    clear_mon();
    start = 1'b1;
    base_addr = base;
    count = 9'(cnt);
    w_ready = pick_ready(mode, stall_left);
    tick();
    start_cyc = cyc;
    k = 1;
    while (done_cnt == 0 && k < 2000) begin
      start = (k == ign_at);
      if (k == ign_at) begin
        base_addr = ~base;
        count = 9'd5;
      end
      w_ready = pick_ready(mode, stall_left);
      tick();
      k++;
    end
    start = 1'b0;
    repeat (3) begin
      w_ready = pick_ready(mode, stall_left);
      tick();
    end

    check({name, " done pulses"}, 32'(done_cnt), 32'd1);
    check({name, " issue count"}, 32'(iss_q.size()), 32'(cnt));
    check({name, " word count"}, 32'(got_q.size()), 32'(cnt));
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      a = base + i[7:0];
      exp_w = {(i == cnt - 1), rom[a]};
      if (i >= iss_q.size() || iss_q[i] !== a) bad++;
      if (i >= got_q.size() || got_q[i] !== exp_w) bad++;
    end
    check({name, " addr/data/last mismatches"}, 32'(bad), 32'd0);
    check({name, " busy after"}, 32'(busy), 32'd0);
    if (cnt == 0) begin
      check({name, " zero done timing"}, 32'(done_cyc - start_cyc), 32'd1);
      check({name, " zero busy seen"}, 32'(busy_seen), 32'd0);
    end else begin
      check({name, " start-to-data"}, 32'(first_valid_cyc - start_cyc), 32'd2);
      check({name, " done after last hs"}, 32'(done_cyc - last_hs_cyc), 32'd1);
      check({name, " occupancy bound"}, 32'(max_out <= 4), 32'd1);
      check({name, " stall stability errs"}, 32'(stall_err), 32'd0);
      if (mode == 0) check({name, " back-to-back issue"}, 32'(iss_last - iss_first), 32'(cnt - 1));
      if (mode == 2) check({name, " issue stalled"}, 32'((iss_last - iss_first) > cnt - 1), 32'd1);
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    clear_mon();

    reset = 1'b1;
    repeat (2) tick();
    check("reset rom_enable", 32'(rom_enable), 32'd0);
    check("reset rom_address", 32'(rom_address), 32'd0);
    check("reset w_valid", 32'(w_valid), 32'd0);
    check("reset w_last", 32'(w_last), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);

    clear_mon();
    start = 1'b1; count = 9'd3; base_addr = 8'h20;
    tick();
    reset = 1'b0; start = 1'b0;
    repeat (4) tick();
    check("start under reset issues", 32'(iss_q.size()), 32'd0);
    check("start under reset busy", 32'(busy_seen), 32'd0);

    run_cmd("basic", 8'h10, 4, 0, -1);
    run_cmd("backpressure", 8'($urandom), 10, 2, -1);
    run_cmd("wrap", 8'hFE, 4, 0, -1);
    run_cmd("zero", 8'h40, 0, 0, -1);
    run_cmd("single", 8'($urandom), 1, 1, -1);
    run_cmd("ignore start", 8'($urandom), 8, 0, 2);

    clear_mon();
    start = 1'b1; base_addr = 8'($urandom); count = 9'd8; w_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (got_q.size() < 3 && k < 100) begin
      tick();
      k++;
    end
    check("abort reached 3 words", 32'(got_q.size() >= 3), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort w_valid", 32'(w_valid), 32'd0);
    check("abort rom_enable", 32'(rom_enable), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    repeat (4) tick();
    check("abort no done", 32'(done_cnt), 32'd0);

    run_cmd("fresh", 8'($urandom), 1 + int'($urandom_range(19)), 0, -1);
    for (int r = 0; r < 4; r++)
      run_cmd("random", 8'($urandom), 1 + int'($urandom_range(39)), 1, -1);
    run_cmd("full span", 8'($urandom), 256, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
